// File: rtl/div_sequencer.sv
// div_sequencer
// Buffers division requests in a small FIFO and feeds them one at a time to an
// external iterative divider, then holds each result for a downstream consumer.
//
// Ports
//   clk                          : clock, all state changes on the rising edge
//   rst                          : asynchronous active-low reset
//   in_valid / in_ready          : upstream request handshake
//   in_dividend / in_divisor     : request operands
//   div_start                    : one-cycle start strobe to the divider
//   div_dividend / div_divisor   : operands of the last issued request
//   div_quotient / div_remainder : divider results
//   div_zeroErr                  : divider reports a zero divisor
//   div_valid                    : divider idle with a valid result
//   out_valid / out_ready        : downstream result handshake
//   out_quotient / out_remainder : result data
//   out_zeroErr                  : result came from a zero divisor
//   fifo_count                   : request FIFO occupancy
//
// DEPTH must be a power of two (>= 2) so the pointers wrap by plain overflow.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_dividend,
  input  logic [WIDTH-1:0]         in_divisor,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_zeroErr,
  input  logic                     div_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_quotient,
  output logic [WIDTH-1:0]         out_remainder,
  output logic                     out_zeroErr,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             start_nxt_s;
  logic             capture_s;
  logic             push_s;
  logic             pop_s;
  logic             in_ready_s;

  logic [WIDTH-1:0] fifo_a_r [DEPTH];
  logic [WIDTH-1:0] fifo_b_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  logic             div_start_r;
  logic [WIDTH-1:0] div_dividend_r;
  logic [WIDTH-1:0] div_divisor_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_quotient_r;
  logic [WIDTH-1:0] out_remainder_r;
  logic             out_zeroErr_r;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign in_ready_s = (count_r != CW'(DEPTH));
  assign push_s     = in_valid && in_ready_s;
  // The head leaves the FIFO at the end of the single ISSUE cycle.
  assign pop_s      = (state_r == ISSUE);

  // Sequencer next state; also flags the IDLE->ISSUE transition and the result capture.
  always_comb begin
    state_nxt_s = state_r;
    start_nxt_s = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A pending result must be consumed before the next request is issued.
        if ((count_r != {CW{1'b0}}) && !out_valid_r) begin
          state_nxt_s = ISSUE;
          start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (div_valid) begin
          state_nxt_s = IDLE;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_a_r[wr_ptr_r] <= in_dividend;
      fifo_b_r[wr_ptr_r] <= in_divisor;
    end
  end

  // FIFO pointers and occupancy; pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Divider strobe and operands, registered one cycle ahead so they line up with ISSUE.
  // The head is stable between IDLE and ISSUE because nothing pops before ISSUE ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_start_r    <= 1'b0;
      div_dividend_r <= {WIDTH{1'b0}};
      div_divisor_r  <= {WIDTH{1'b0}};
    end else begin
      div_start_r <= start_nxt_s;
      if (start_nxt_s) begin
        div_dividend_r <= fifo_a_r[rd_ptr_r];
        div_divisor_r  <= fifo_b_r[rd_ptr_r];
      end
    end
  end

  // Result slot; a zero divisor reports all-ones quotient and the issued dividend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r     <= 1'b0;
      out_quotient_r  <= {WIDTH{1'b0}};
      out_remainder_r <= {WIDTH{1'b0}};
      out_zeroErr_r   <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      if (div_zeroErr) begin
        out_quotient_r  <= {WIDTH{1'b1}};
        out_remainder_r <= div_dividend_r;
        out_zeroErr_r   <= 1'b1;
      end else begin
        out_quotient_r  <= div_quotient;
        out_remainder_r <= div_remainder;
        out_zeroErr_r   <= 1'b0;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready      = in_ready_s;
  assign fifo_count    = count_r;
  assign div_start     = div_start_r;
  assign div_dividend  = div_dividend_r;
  assign div_divisor   = div_divisor_r;
  assign out_valid     = out_valid_r;
  assign out_quotient  = out_quotient_r;
  assign out_remainder = out_remainder_r;
  assign out_zeroErr   = out_zeroErr_r;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Drives div_sequencer with directed and random requests, emulates a divider with
// random latency, and checks every cycle against a transaction-level model
// (request queue, occupancy count, in-flight flag, expected result slot).
module tb_div_sequencer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_dividend;
  logic [W-1:0]  in_divisor;
  logic          div_start;
  logic [W-1:0]  div_dividend;
  logic [W-1:0]  div_divisor;
  logic [W-1:0]  div_quotient;
  logic [W-1:0]  div_remainder;
  logic          div_zeroErr;
  logic          div_valid;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_quotient;
  logic [W-1:0]  out_remainder;
  logic          out_zeroErr;
  logic [CW-1:0] fifo_count;

  div_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_zeroErr(div_zeroErr), .div_valid(div_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_zeroErr(out_zeroErr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  logic [2*W-1:0] mq[$];
  int             mcount    = 0;
  logic           inflight  = 1'b0;
  logic           exp_start = 1'b0;
  logic           m_ov      = 1'b0;
  logic [W-1:0]   m_q = '0, m_r = '0;
  logic           m_z = 1'b0;
  logic [W-1:0]   e_q = '0, e_r = '0;
  logic           e_z = 1'b0;
  logic [W-1:0]   last_a = '0, last_b = '0;
  int             cyc = 0, start_cnt = 0, issue_cyc = 0, acc_cyc = 0;
  logic [W-1:0]   log_q[$];
  logic [W-1:0]   log_r[$];
  logic           log_z[$];

  int             ord_mode = 0;
  int             lat_fix  = -1;

  // Compare process: samples 2 time units before each rising edge.
  initial begin
    logic [2*W-1:0] head;
    logic push, nstart, capture;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst) begin
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_quotient", out_quotient, '0);
        chk("rst_out_remainder", out_remainder, '0);
        chk("rst_out_zeroErr", out_zeroErr, 1'b0);
        chk("rst_div_start", div_start, 1'b0);
        chk("rst_div_ops", {div_dividend, div_divisor}, '0);
        chk("rst_fifo_count", fifo_count, '0);
        mq.delete();
        mcount = 0; inflight = 1'b0; exp_start = 1'b0; m_ov = 1'b0;
        last_a = '0; last_b = '0;
      end else begin
        chk("in_ready", in_ready, (mcount != D));
        chk("fifo_count", fifo_count, mcount);
        chk("div_start", div_start, exp_start);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
          chk("out_quotient", out_quotient, m_q);
          chk("out_remainder", out_remainder, m_r);
          chk("out_zeroErr", out_zeroErr, m_z);
        end
        push = in_valid && (mcount != D);
        if (div_start) begin
          start_cnt++;
          issue_cyc = cyc;
          if (mq.size() == 0) begin
            chk("issue_from_empty", 64'd1, 64'd0);
          end else begin
            head = mq.pop_front();
            chk("issue_dividend", div_dividend, head[2*W-1:W]);
            chk("issue_divisor", div_divisor, head[W-1:0]);
            last_a = head[2*W-1:W];
            last_b = head[W-1:0];
            e_z = (last_b == '0);
            e_q = e_z ? {W{1'b1}} : last_a / last_b;
            e_r = e_z ? last_a : last_a % last_b;
            mcount--;
          end
        end else begin
          chk("held_dividend", div_dividend, last_a);
          chk("held_divisor", div_divisor, last_b);
        end
        // Issue rule: idle (nothing in flight), queued work, empty output slot.
        nstart  = !inflight && !div_start && (mcount + (div_start ? 1 : 0) > 0) && !m_ov;
        capture = inflight && !div_start && div_valid;
        if (m_ov && out_ready) begin
          log_q.push_back(out_quotient);
          log_r.push_back(out_remainder);
          log_z.push_back(out_zeroErr);
          m_ov = 1'b0;
        end
        if (capture) begin
          m_ov = 1'b1; m_q = e_q; m_r = e_r; m_z = e_z;
          inflight = 1'b0;
        end
        if (div_start) inflight = 1'b1;
        if (push) begin
          mq.push_back({in_dividend, in_divisor});
          mcount++;
          acc_cyc = cyc;
        end
        exp_start = nstart;
      end
    end
  end

  // Divider emulation: random latency, zero divisor answers at once, garbage while busy.
  initial begin
    logic [W-1:0] a, b;
    int cnt;
    cnt = 0; a = '0; b = '1;
    div_valid = 1'b1; div_zeroErr = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        a = div_dividend; b = div_divisor;
        cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        if (b == '0) cnt = 0;
        if (cnt == 0) begin
          div_valid = 1'b1; div_zeroErr = (b == '0);
          div_quotient  = (b == '0) ? $urandom : a / b;
          div_remainder = (b == '0) ? $urandom : a % b;
        end else begin
          div_valid = 1'b0; div_zeroErr = $urandom_range(0, 1);
          div_quotient = $urandom; div_remainder = $urandom;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_valid = 1'b1; div_zeroErr = 1'b0;
          div_quotient = a / b; div_remainder = a % b;
        end
      end
    end
  end

  // Downstream ready pattern: 0 low, 1 high, 2 toggle, other random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (ord_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = $urandom_range(0, 1);
      endcase
    end
  end

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    #3;
    while (!in_ready && n < 300) begin
      @(negedge clk); #3; n++;
    end
    chk("send_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_log(input int target);
    int n;
    n = 0;
    while (log_q.size() < target && n < 400) begin
      @(negedge clk); n++;
    end
    chk("wait_result", (log_q.size() >= target), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, s0, n;
    logic [W-1:0] ta[6];
    logic [W-1:0] tb[6];
    logic [W-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #3;
    chk("in_ready_after_reset", in_ready, 1'b1);
    @(negedge clk);

    // 100/7 with downstream always ready
    ord_mode = 1;
    n0 = log_q.size(); s0 = start_cnt;
    send(32'd100, 32'd7);
    wait_log(n0 + 1);
    chk("t1_quotient", log_q[n0], 32'd14);
    chk("t1_remainder", log_r[n0], 32'd2);
    chk("t1_zeroErr", log_z[n0], 1'b0);
    chk("t1_start_pulses", start_cnt - s0, 1);
    chk("t1_issued_ops", {last_a, last_b}, {32'd100, 32'd7});
    chk("t1_latency", issue_cyc - acc_cyc, 2);

    // 5/0
    n0 = log_q.size();
    send(32'd5, 32'd0);
    wait_log(n0 + 1);
    chk("t2_quotient", log_q[n0], 32'hFFFF_FFFF);
    chk("t2_remainder", log_r[n0], 32'd5);
    chk("t2_zeroErr", log_z[n0], 1'b1);

    // Six back-to-back requests against a stalled consumer
    ord_mode = 0;
    repeat (2) @(negedge clk);
    n0 = log_q.size(); s0 = start_cnt;
    for (int i = 0; i < 6; i++) begin
      ta[i] = 32'd60 + 32'(i);
      tb[i] = (i == 5) ? 32'd0 : 32'd3 + 32'(i);
    end
    for (int i = 0; i < 5; i++) send(ta[i], tb[i]);
    in_valid = 1'b1; in_dividend = ta[5]; in_divisor = tb[5];
    repeat (12) @(negedge clk);
    #3;
    chk("t3_fifo_full", fifo_count, 3'd4);
    chk("t3_in_ready", in_ready, 1'b0);
    chk("t3_one_start", start_cnt - s0, 1);
    chk("t3_out_valid", out_valid, 1'b1);
    ord_mode = 1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #3; n++;
    end
    chk("t3_req6_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_log(n0 + 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_order_q", log_q[n0+i], (tb[i] == '0) ? 32'hFFFF_FFFF : ta[i] / tb[i]);
      chk("t3_order_r", log_r[n0+i], (tb[i] == '0) ? ta[i] : ta[i] % tb[i]);
    end

    // Three requests with a toggling consumer
    ord_mode = 2;
    n0 = log_q.size();
    send(32'd9, 32'd2);
    send(32'd8, 32'd4);
    send(32'd7, 32'd7);
    wait_log(n0 + 3);
    chk("t4_r1", {log_q[n0],   log_r[n0]},   {32'd4, 32'd1});
    chk("t4_r2", {log_q[n0+1], log_r[n0+1]}, {32'd2, 32'd0});
    chk("t4_r3", {log_q[n0+2], log_r[n0+2]}, {32'd1, 32'd0});

    // Reset while waiting on the divider
    ord_mode = 1;
    lat_fix = 3;
    s0 = start_cnt;
    send(32'd50, 32'd6);
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("t5_issued", start_cnt - s0, 1);
    n0 = log_q.size();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lat_fix = -1;
    #3;
    chk("t5_in_ready", in_ready, 1'b1);
    @(negedge clk);
    send(32'd10, 32'd3);
    wait_log(n0 + 1);
    repeat (4) @(negedge clk);
    chk("t5_single_result", log_q.size(), n0 + 1);
    chk("t5_quotient", log_q[n0], 32'd3);
    chk("t5_remainder", log_r[n0], 32'd1);

    // Random traffic
    ord_mode = 3;
    n0 = log_q.size();
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 50);
      else b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
      send(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ord_mode = 1;
    wait_log(n0 + 300);
    repeat (4) @(negedge clk);
    chk("drain_count", log_q.size(), n0 + 300);
    chk("drain_model_empty", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the request FIFO depth; DEPTH SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: an upstream request is present.
REQ-006 Port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 Port in_dividend, input, WIDTH bits: request dividend.
REQ-008 Port in_divisor, input, WIDTH bits: request divisor.
REQ-009 Port div_start, output, 1 bit: start strobe to the divider.
REQ-010 Ports div_dividend and div_divisor, outputs, WIDTH bits each: operands to the divider.
REQ-011 Ports div_quotient and div_remainder, inputs, WIDTH bits each: divider results.
REQ-012 Port div_zeroErr, input, 1 bit: divider divide-by-zero flag.
REQ-013 Port div_valid, input, 1 bit: divider idle with a valid result.
REQ-014 Port out_valid, output, 1 bit: a result is presented downstream.
REQ-015 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-016 Ports out_quotient and out_remainder, outputs, WIDTH bits each: result data.
REQ-017 Port out_zeroErr, output, 1 bit: the result came from a zero divisor.
REQ-018 Port fifo_count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-019 The FIFO SHALL accept a request on a rising edge when in_valid and in_ready are both 1.
REQ-020 in_ready SHALL equal (fifo_count != DEPTH); a push SHALL NOT occur when the FIFO is full, even if a pop happens in the same cycle.
REQ-021 The FIFO read and write pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-022 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-023 The FSM SHALL move from IDLE to ISSUE when fifo_count > 0 and out_valid = 0, and SHALL otherwise stay in IDLE.
REQ-024 In ISSUE, div_start SHALL be 1 for exactly one cycle with div_dividend and div_divisor equal to the FIFO head; at the end of that cycle the head SHALL be popped and the FSM SHALL enter WAIT.
REQ-025 div_start SHALL be 0 in every state other than ISSUE; div_dividend and div_divisor SHALL hold the last issued operands outside ISSUE.
REQ-026 In WAIT, on the first rising edge with div_valid = 1, the block SHALL capture the result, set out_valid to 1 and return to IDLE; div_valid may already be 1 on the first WAIT cycle (zero divisor or cached result).
REQ-027 Captured result when div_zeroErr = 0: out_quotient = div_quotient, out_remainder = div_remainder, out_zeroErr = 0.
REQ-028 Captured result when div_zeroErr = 1: out_quotient = all ones, out_remainder = the issued dividend, out_zeroErr = 1.
REQ-029 out_valid SHALL stay 1, with out_* held stable, until the rising edge on which out_ready = 1; it SHALL then clear.
REQ-030 Latency: a request accepted at edge k into an empty FIFO, with the output slot empty, SHALL drive div_start during the cycle after edge k+1.
REQ-031 At most one request SHALL be in flight at the divider, and results SHALL be delivered in request order.

Reset
REQ-032 While rst = 0, asynchronously: state = IDLE, FIFO empty, fifo_count = 0, out_valid = 0, out_quotient = 0, out_remainder = 0, out_zeroErr = 0, div_start = 0, div_dividend = 0, div_divisor = 0.
REQ-033 A reset asserted in WAIT SHALL discard the in-flight request, and its divider result SHALL never appear on out_*.
REQ-034 in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-035 Push 100/7 with out_ready = 1 -> exactly one div_start pulse with operands 100 and 7, then out_quotient = 14, out_remainder = 2, out_zeroErr = 0.
REQ-036 Push 5/0 -> out_zeroErr = 1, out_quotient = 0xFFFFFFFF, out_remainder = 5, with no hang in WAIT.
REQ-037 Hold out_ready = 0 and offer 6 requests back-to-back -> request 1 is issued, requests 2-5 fill the FIFO (fifo_count = 4, in_ready = 0), request 6 stalls, and no second div_start occurs.
REQ-038 Push 3 requests (9/2, 8/4, 7/7) with out_ready toggling -> results (4,1), (2,0), (1,0) delivered in order, out_* stable while out_valid = 1 and out_ready = 0.
REQ-039 Assert rst low mid-WAIT, then release and push 10/3 -> the earlier result is never presented, and out_quotient = 3, out_remainder = 1.
